// File: rtl/alu_seq_psr_pkg.sv
// alu_seq_psr_pkg: shared opcodes, PSR bit positions and FSM states
package alu_seq_psr_pkg;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b1000;
  localparam logic [3:0] OP_LSH = 4'b1001;
  localparam logic [3:0] OP_LUI = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
endpackage

// File: rtl/alu_seq_psr_flag_gen.sv
// alu_flag_gen: combinational {N,Z,F,L,C} flag vector from operands and result
module alu_flag_gen #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] result,
  input  logic             cout,
  input  logic             is_add,
  input  logic             is_sub,
  output logic [4:0]       flags
);
  import alu_seq_psr_pkg::*;
  logic ds, ss, rs;
  assign ds = dst[WIDTH-1];
  assign ss = src[WIDTH-1];
  assign rs = result[WIDTH-1];
  always_comb begin
    flags = '0;
    flags[PSR_Z] = result == '0;
    flags[PSR_L] = dst < src;
    flags[PSR_N] = $signed(dst) < $signed(src);
    flags[PSR_C] = (is_add || is_sub) && cout;
    flags[PSR_F] = is_add ? (ds == ss && rs != ds) : is_sub ? (ds != ss && rs == ss) : 1'b0;
  end
endmodule

// File: rtl/alu_seq_psr.sv
// alu_seq_psr: multi-cycle ALU with registered result/PSR, iterative shifter and multiplier
module alu_seq_psr #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic             flag_we,
  input  logic [WIDTH-1:0] reg_dst,
  input  logic [WIDTH-1:0] reg_src,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic [4:0]       psr
);
  import alu_seq_psr_pkg::*;
  localparam logic [SHW-1:0] CNT_W = SHW'(WIDTH);
  state_t state, state_n;
  logic [SHW-1:0] cnt, amt, mag_raw, mag;
  logic [WIDTH-1:0] work, mplr, acc, dst_q, src_q, sc_result, fin_result, step;
  logic [WIDTH:0] sum, diff;
  logic left, fwe_q, accept, last, go_shift, go_mul;
  logic [4:0] flags;
  assign ready = state == S_IDLE;
  assign busy = !ready;
  assign accept = start && ready;
  assign amt = reg_src[SHW-1:0];
  assign mag_raw = amt[SHW-1] ? -amt : amt;
  assign mag = mag_raw > CNT_W ? CNT_W : mag_raw;
  assign go_shift = accept && alu_op == OP_LSH && mag != '0;
  assign go_mul = accept && alu_op == OP_MUL;
  assign last = cnt == SHW'(1);
  assign sum = {1'b0, reg_dst} + {1'b0, reg_src};
  assign diff = {1'b0, reg_dst} - {1'b0, reg_src};
  assign step = (state == S_MUL || left) ? work << 1 : work >> 1;
  // final multiply iteration folds in the last partial product directly
  assign fin_result = state == S_SHIFT ? step : acc + (mplr[0] ? work : '0);
  always_comb begin
    sc_result = reg_dst;
    case (alu_op)
      OP_ADD: sc_result = sum[WIDTH-1:0];
      OP_SUB: sc_result = diff[WIDTH-1:0];
      OP_AND: sc_result = reg_dst & reg_src;
      OP_OR:  sc_result = reg_dst | reg_src;
      OP_XOR: sc_result = reg_dst ^ reg_src;
      OP_MOV: sc_result = reg_src;
      OP_LUI: sc_result = {reg_src[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: sc_result = reg_dst;
    endcase
  end
  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .dst    (ready ? reg_dst : dst_q),
    .src    (ready ? reg_src : src_q),
    .result (ready ? sc_result : fin_result),
    .cout   (alu_op == OP_SUB ? diff[WIDTH] : sum[WIDTH]),
    .is_add (ready && alu_op == OP_ADD),
    .is_sub (ready && alu_op == OP_SUB),
    .flags  (flags)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (ready) state_n = go_shift ? S_SHIFT : go_mul ? S_MUL : S_IDLE;
    else if (last) state_n = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      work <= '0;
      mplr <= '0;
      acc <= '0;
      dst_q <= '0;
      src_q <= '0;
      left <= 1'b0;
      fwe_q <= 1'b0;
      done <= 1'b0;
      alu_result <= '0;
      psr <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dst_q <= reg_dst;
        src_q <= reg_src;
        fwe_q <= flag_we;
        work <= reg_dst;
        mplr <= reg_src;
        acc <= '0;
        left <= !amt[SHW-1];
        cnt <= go_mul ? CNT_W : mag;
        if (!go_shift && !go_mul) begin
          alu_result <= sc_result;
          done <= 1'b1;
          if (flag_we) psr <= flags;
        end
      end else if (busy) begin
        work <= step;
        cnt <= cnt - SHW'(1);
        mplr <= mplr >> 1;
        if (mplr[0]) acc <= acc + work;
        if (last) begin
          alu_result <= fin_result;
          done <= 1'b1;
          if (fwe_q) psr <= flags;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_psr.sv
// tb_alu_seq_psr: directed vectors with hand-computed results for alu_seq_psr
module tb_alu_seq_psr;
  import alu_seq_psr_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, flag_we = 1'b0;
  logic [3:0] alu_op = '0;
  logic [15:0] reg_dst = '0, reg_src = '0, alu_result;
  logic ready, busy, done;
  logic [4:0] psr;
  int n_vec = 0, n_bad = 0;
  alu_seq_psr dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .flag_we(flag_we),
    .reg_dst(reg_dst), .reg_src(reg_src), .ready(ready), .busy(busy), .done(done),
    .alu_result(alu_result), .psr(psr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [15:0] d, input logic [15:0] s, input logic we);
    @(negedge clk);
    start = 1'b1;
    alu_op = op;
    reg_dst = d;
    reg_src = s;
    flag_we = we;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1 k++;
    end while (!done && k < 64);
  endtask
  logic [3:0] bb_op [4] = '{OP_AND, OP_OR, OP_XOR, OP_LUI};
  logic [15:0] bb_exp [4] = '{16'h000F, 16'h0FFF, 16'h0FF0, 16'hFF00};
  int k, pulses;
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", alu_result, 0);
    chk("rst_psr", psr, 0);
    issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b1);
    chk("add_done", done, 1);
    chk("add_res", alu_result, 16'h8000);
    chk("add_psr", psr, 5'b00100);
    issue(OP_SUB, 16'h0001, 16'h0002, 1'b1);
    chk("sub_res", alu_result, 16'hFFFF);
    chk("sub_psr", psr, 5'b10011);
    issue(OP_SUB, 16'h0005, 16'h0005, 1'b1);
    chk("subz_res", alu_result, 16'h0000);
    chk("subz_psr", psr, 5'b01000);
    issue(OP_ADD, 16'h0003, 16'h0004, 1'b0);
    chk("addnw_res", alu_result, 16'h0007);
    chk("addnw_psr", psr, 5'b01000);
    issue(OP_LSH, 16'h0001, 16'h0004, 1'b1);
    chk("lsh_busy", busy, 1);
    chk("lsh_nodone", done, 0);
    wait_done(k);
    chk("lsh_lat", k, 4);
    chk("lsh_res", alu_result, 16'h0010);
    chk("lsh_psr", psr, 5'b10010);
    issue(OP_LSH, 16'h8000, 16'hFFFC, 1'b0);
    wait_done(k);
    chk("lshr_lat", k, 4);
    chk("lshr_res", alu_result, 16'h0800);
    chk("lshr_psr", psr, 5'b10010);
    issue(OP_LSH, 16'h1234, 16'h0000, 1'b0);
    chk("lsh0_done", done, 1);
    chk("lsh0_ready", ready, 1);
    chk("lsh0_res", alu_result, 16'h1234);
    issue(OP_MUL, 16'h0123, 16'h0010, 1'b0);
    chk("mul_busy", busy, 1);
    repeat (4) @(posedge clk);
    issue(OP_ADD, 16'h0001, 16'h0001, 1'b0);
    chk("mul_ign_busy", busy, 1);
    wait_done(k);
    chk("mul_lat", k + 5, 16);
    chk("mul_res", alu_result, 16'h1230);
    @(posedge clk);
    #1 chk("mul_nodup", done, 0);
    chk("mul_hold", alu_result, 16'h1230);
    issue(OP_MUL, 16'h0123, 16'h0010, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", alu_result, 0);
    chk("abort_psr", psr, 0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done) pulses++;
    end
    chk("abort_nodone", pulses, 0);
    issue(OP_ADD, 16'h0002, 16'h0002, 1'b1);
    chk("post_done", done, 1);
    chk("post_res", alu_result, 16'h0004);
    for (int i = 0; i < 4; i++) begin
      issue(bb_op[i], 16'h0F0F, 16'h00FF, 1'b0);
      chk($sformatf("bb%0d_done", i), done, 1);
      chk($sformatf("bb%0d_res", i), alu_result, bb_exp[i]);
    end
    @(posedge clk);
    #1 chk("bb_end", done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
